// File: rtl/wb_regfile_if.sv
// Bus bundle for the writeback register file: writeback, two read ports,
// write counter and the debug read channel.
interface wb_regfile_if;
  logic        MemtoReg_i;
  logic        RegWrite_i;
  logic [31:0] Data_i;
  logic [31:0] Result_i;
  logic [4:0]  RD_i;
  logic [4:0]  RS_addr_i;
  logic [4:0]  RT_addr_i;
  logic [31:0] RS_data_o;
  logic [31:0] RT_data_o;
  logic [31:0] wb_data_o;
  logic [31:0] wcount_o;
  logic        dbg_req_i;
  logic [4:0]  dbg_addr_i;
  logic        dbg_ack_o;
  logic [31:0] dbg_data_o;

  modport slave (
    input  MemtoReg_i, RegWrite_i, Data_i, Result_i, RD_i,
    input  RS_addr_i, RT_addr_i, dbg_req_i, dbg_addr_i,
    output RS_data_o, RT_data_o, wb_data_o, wcount_o, dbg_ack_o, dbg_data_o
  );

  modport master (
    output MemtoReg_i, RegWrite_i, Data_i, Result_i, RD_i,
    output RS_addr_i, RT_addr_i, dbg_req_i, dbg_addr_i,
    input  RS_data_o, RT_data_o, wb_data_o, wcount_o, dbg_ack_o, dbg_data_o
  );
endinterface

// File: rtl/wb_regfile.sv
// Register file with writeback mux, write-to-read bypass, committed-write
// counter and a three-state debug read port that never bypasses.
module wb_regfile #(
  parameter int DEPTH = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  wb_regfile_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_ACK  = 2'd2
  } dbg_state_e;

  logic [31:0] regs_q [DEPTH];
  logic        wr_en_s;
  logic [31:0] wb_data_s;
  logic [31:0] rs_data_s;
  logic [31:0] rt_data_s;
  logic [31:0] wcount_q;
  logic [31:0] wcount_d;
  dbg_state_e  state_q;
  dbg_state_e  state_d;
  logic [4:0]  dbg_addr_q;
  logic [4:0]  dbg_addr_d;
  logic [31:0] dbg_data_q;
  logic [31:0] dbg_data_d;
  logic        dbg_ack_q;
  logic        dbg_ack_d;

  // Writeback source select and commit qualification
  always_comb begin
    if (bus.MemtoReg_i) begin
      wb_data_s = bus.Data_i;
    end else begin
      wb_data_s = bus.Result_i;
    end
    wr_en_s  = bus.RegWrite_i && (bus.RD_i != 5'd0);
    wcount_d = wr_en_s ? (wcount_q + 32'd1) : wcount_q;
  end

  // Read ports: an in-flight write to the same index wins over the array
  always_comb begin
    if (wr_en_s && (bus.RD_i == bus.RS_addr_i)) begin
      rs_data_s = wb_data_s;
    end else if (bus.RS_addr_i == 5'd0) begin
      rs_data_s = 32'd0;
    end else begin
      rs_data_s = regs_q[bus.RS_addr_i];
    end
    if (wr_en_s && (bus.RD_i == bus.RT_addr_i)) begin
      rt_data_s = wb_data_s;
    end else if (bus.RT_addr_i == 5'd0) begin
      rt_data_s = 32'd0;
    end else begin
      rt_data_s = regs_q[bus.RT_addr_i];
    end
  end

  // Register array and write counter; reset blocks writes
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= 32'd0;
      end
      wcount_q <= 32'd0;
    end else begin
      if (wr_en_s) begin
        regs_q[bus.RD_i] <= wb_data_s;
      end
      wcount_q <= wcount_d;
    end
  end

  // Debug FSM next state; READ samples the array before this edge's write
  always_comb begin
    state_d    = state_q;
    dbg_addr_d = dbg_addr_q;
    dbg_data_d = dbg_data_q;
    dbg_ack_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.dbg_req_i) begin
          dbg_addr_d = bus.dbg_addr_i;
          state_d    = ST_READ;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_READ: begin
        if (dbg_addr_q == 5'd0) begin
          dbg_data_d = 32'd0;
        end else begin
          dbg_data_d = regs_q[dbg_addr_q];
        end
        dbg_ack_d = 1'b1;
        state_d   = ST_ACK;
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Debug FSM state and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      dbg_addr_q <= 5'd0;
      dbg_data_q <= 32'd0;
      dbg_ack_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dbg_addr_q <= dbg_addr_d;
      dbg_data_q <= dbg_data_d;
      dbg_ack_q  <= dbg_ack_d;
    end
  end

  assign bus.wb_data_o  = wb_data_s;
  assign bus.RS_data_o  = rs_data_s;
  assign bus.RT_data_o  = rt_data_s;
  assign bus.wcount_o   = wcount_q;
  assign bus.dbg_data_o = dbg_data_q;
  assign bus.dbg_ack_o  = dbg_ack_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile with hand-computed expectations.
module tb_wb_regfile;

  logic clk_i;
  logic rst_i;
  int   n_cmp;
  int   n_mis;
  int   n_ack;

  wb_regfile_if bus_if ();

  wb_regfile #(.DEPTH(32)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus_if)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // advance to the next falling edge, passing one rising edge
  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic idle_bus();
    bus_if.MemtoReg_i = 1'b0;
    bus_if.RegWrite_i = 1'b0;
    bus_if.Data_i     = 32'd0;
    bus_if.Result_i   = 32'd0;
    bus_if.RD_i       = 5'd0;
    bus_if.dbg_req_i  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_cmp = 0;
    n_mis = 0;
    idle_bus();
    bus_if.RS_addr_i  = 5'd0;
    bus_if.RT_addr_i  = 5'd0;
    bus_if.dbg_addr_i = 5'd0;
    rst_i = 1'b1;
    #1;
    check_eq("rst_wcount", bus_if.wcount_o, 32'd0);
    check_eq("rst_ack", {31'd0, bus_if.dbg_ack_o}, 32'd0);
    check_eq("rst_dbgdata", bus_if.dbg_data_o, 32'd0);

    // bypass still works in reset, but the write must not land
    @(negedge clk_i);
    bus_if.RegWrite_i = 1'b1;
    bus_if.RD_i       = 5'd3;
    bus_if.Result_i   = 32'h0000_00AA;
    bus_if.RS_addr_i  = 5'd3;
    #1;
    check_eq("rst_bypass", bus_if.RS_data_o, 32'h0000_00AA);
    step();
    idle_bus();
    #1;
    check_eq("rst_noWrite", bus_if.RS_data_o, 32'd0);
    check_eq("rst_noCount", bus_if.wcount_o, 32'd0);
    rst_i = 1'b0;

    // ALU result writeback to r5
    step();
    bus_if.RegWrite_i = 1'b1;
    bus_if.RD_i       = 5'd5;
    bus_if.Result_i   = 32'h1234_5678;
    bus_if.Data_i     = 32'hDEAD_BEEF;
    #1;
    check_eq("wb_result", bus_if.wb_data_o, 32'h1234_5678);
    step();
    idle_bus();
    bus_if.RS_addr_i = 5'd5;
    #1;
    check_eq("r5_read", bus_if.RS_data_o, 32'h1234_5678);
    check_eq("wcount1", bus_if.wcount_o, 32'd1);

    // memory data writeback to r9
    bus_if.RegWrite_i = 1'b1;
    bus_if.MemtoReg_i = 1'b1;
    bus_if.RD_i       = 5'd9;
    bus_if.Data_i     = 32'h0BAD_F00D;
    bus_if.Result_i   = 32'h1111_1111;
    #1;
    check_eq("wb_data", bus_if.wb_data_o, 32'h0BAD_F00D);
    step();
    idle_bus();
    bus_if.RT_addr_i = 5'd9;
    #1;
    check_eq("r9_read", bus_if.RT_data_o, 32'h0BAD_F00D);
    check_eq("wcount2", bus_if.wcount_o, 32'd2);

    // writes to r0 are dropped and not counted
    bus_if.RegWrite_i = 1'b1;
    bus_if.RD_i       = 5'd0;
    bus_if.Result_i   = 32'hFFFF_FFFF;
    bus_if.RS_addr_i  = 5'd0;
    #1;
    check_eq("r0_nobypass", bus_if.RS_data_o, 32'd0);
    step();
    idle_bus();
    #1;
    check_eq("r0_read", bus_if.RS_data_o, 32'd0);
    check_eq("r0_wcount", bus_if.wcount_o, 32'd2);

    // same-cycle bypass on both ports
    bus_if.RegWrite_i = 1'b1;
    bus_if.MemtoReg_i = 1'b1;
    bus_if.RD_i       = 5'd7;
    bus_if.Data_i     = 32'hCAFE_F00D;
    bus_if.RS_addr_i  = 5'd7;
    bus_if.RT_addr_i  = 5'd7;
    #1;
    check_eq("byp_rs", bus_if.RS_data_o, 32'hCAFE_F00D);
    check_eq("byp_rt", bus_if.RT_data_o, 32'hCAFE_F00D);
    step();
    idle_bus();
    #1;
    check_eq("r7_stored", bus_if.RS_data_o, 32'hCAFE_F00D);
    check_eq("wcount3", bus_if.wcount_o, 32'd3);

    // single debug read of r5
    bus_if.dbg_req_i  = 1'b1;
    bus_if.dbg_addr_i = 5'd5;
    step();
    bus_if.dbg_req_i  = 1'b0;
    bus_if.dbg_addr_i = 5'd0;
    #1;
    check_eq("dbg_ack_e0", {31'd0, bus_if.dbg_ack_o}, 32'd0);
    step();
    check_eq("dbg_ack_e1", {31'd0, bus_if.dbg_ack_o}, 32'd1);
    check_eq("dbg_data_r5", bus_if.dbg_data_o, 32'h1234_5678);
    step();
    check_eq("dbg_ack_e2", {31'd0, bus_if.dbg_ack_o}, 32'd0);
    check_eq("dbg_hold", bus_if.dbg_data_o, 32'h1234_5678);

    // debug read racing a write to the same register
    bus_if.dbg_req_i  = 1'b1;
    bus_if.dbg_addr_i = 5'd5;
    step();
    bus_if.dbg_req_i  = 1'b0;
    bus_if.RegWrite_i = 1'b1;
    bus_if.RD_i       = 5'd5;
    bus_if.Result_i   = 32'h5555_5555;
    bus_if.RS_addr_i  = 5'd5;
    bus_if.RT_addr_i  = 5'd9;
    #1;
    check_eq("byp_rs_only", bus_if.RS_data_o, 32'h5555_5555);
    check_eq("byp_rt_other", bus_if.RT_data_o, 32'h0BAD_F00D);
    step();
    idle_bus();
    #1;
    check_eq("dbg_race_old", bus_if.dbg_data_o, 32'h1234_5678);
    check_eq("dbg_race_ack", {31'd0, bus_if.dbg_ack_o}, 32'd1);
    check_eq("wcount4", bus_if.wcount_o, 32'd4);
    step();
    bus_if.dbg_req_i = 1'b1;
    step();
    bus_if.dbg_req_i = 1'b0;
    step();
    check_eq("dbg_race_new", bus_if.dbg_data_o, 32'h5555_5555);
    step();

    // request held high: one transaction every three cycles
    n_ack = 0;
    bus_if.dbg_req_i  = 1'b1;
    bus_if.dbg_addr_i = 5'd9;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus_if.dbg_ack_o) n_ack++;
    end
    bus_if.dbg_req_i = 1'b0;
    check_eq("held_acks", n_ack, 32'd2);
    check_eq("held_data", bus_if.dbg_data_o, 32'h0BAD_F00D);
    step();
    step();

    // write counter wrap
    force dut.wcount_q = 32'hFFFF_FFFF;
    #1;
    release dut.wcount_q;
    #1;
    check_eq("wcount_forced", bus_if.wcount_o, 32'hFFFF_FFFF);
    bus_if.RegWrite_i = 1'b1;
    bus_if.RD_i       = 5'd10;
    bus_if.Result_i   = 32'd1;
    step();
    idle_bus();
    #1;
    check_eq("wcount_wrap", bus_if.wcount_o, 32'd0);

    // reset mid-cycle while the debug FSM sits in READ
    bus_if.dbg_req_i  = 1'b1;
    bus_if.dbg_addr_i = 5'd5;
    bus_if.RS_addr_i  = 5'd5;
    @(posedge clk_i);
    #2;
    rst_i = 1'b1;
    bus_if.dbg_req_i = 1'b0;
    #1;
    check_eq("mid_rst_wcount", bus_if.wcount_o, 32'd0);
    check_eq("mid_rst_ack", {31'd0, bus_if.dbg_ack_o}, 32'd0);
    check_eq("mid_rst_data", bus_if.dbg_data_o, 32'd0);
    check_eq("mid_rst_r5", bus_if.RS_data_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    n_ack = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus_if.dbg_ack_o) n_ack++;
    end
    check_eq("abort_noack", n_ack, 32'd0);
    check_eq("post_rst_r5", bus_if.RS_data_o, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
